// File: rtl/alu_arbiter.sv
// Two-requester front end that shares one combinational ALU.
// Results are delivered through a single registered response slot.

module alu_core #(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [3:0]        ctl,
    output logic [DWIDTH-1:0] out
);

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_NOR = 4'd12
    } alu_op_e;

    always_comb begin
        out = '0;
        case (ctl)
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_ADD: out = a + b;
            OP_SUB: out = a - b;
            OP_SLT: out = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: out = ~(a | b);
            default: out = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic [3:0]        req0_ctl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    input  logic [3:0]        req1_ctl,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DWIDTH-1:0] resp_out,
    output logic              resp_zero
);

    logic              last_grant;
    logic              slot_free;
    logic              grant_valid;
    logic              grant_idx;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [3:0]        alu_ctl;
    logic [DWIDTH-1:0] alu_out;

    assign slot_free = !resp_valid || resp_ready;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_valid = slot_free && (req0_valid || req1_valid) && !rst;
        grant_idx   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    assign req0_ready = grant_valid && !grant_idx;
    assign req1_ready = grant_valid &&  grant_idx;

    always_comb begin
        alu_a   = grant_idx ? req1_a   : req0_a;
        alu_b   = grant_idx ? req1_b   : req0_b;
        alu_ctl = grant_idx ? req1_ctl : req0_ctl;
    end

    alu_core #(.DWIDTH(DWIDTH)) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .ctl (alu_ctl),
        .out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_zero  <= 1'b0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_valid) begin
            resp_valid <= 1'b1;
            resp_out   <= alu_out;
            resp_zero  <= (alu_out == '0);
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
